// File: rtl/robo_command_sequencer.sv
// robo_command_sequencer
//   Turns one-cycle advance/turn/collect decisions from the robot FSM into
//   timed actuator pulses, acknowledges completion, and tracks how many
//   items are in the trash bin.
//
// Optional feature: define ROBO_BIN_LIMIT_EN to enable the FULL state.
// With it, collection halts at BIN_CAPACITY until bin_empty. Without it,
// bin_full is tied to 0 and trash_count saturates at BIN_CAPACITY.
//
// Ports
//   clock        in  system clock, rising edge
//   reset        in  synchronous, active-high
//   advance      in  advance request (sampled only in IDLE)
//   turn         in  turn request    (sampled only in IDLE)
//   collect      in  collect request (sampled only in IDLE)
//   bin_empty    in  one-cycle pulse: bin was emptied, clears trash_count
//   motor_fwd    out forward drive, ADVANCE_CYCLES long
//   motor_rot    out rotate drive, TURN_CYCLES long
//   arm_on       out collector arm, COLLECT_CYCLES long
//   busy         out high whenever not IDLE
//   ack          out one-cycle pulse when a command completes
//   bin_full     out bin at capacity, collection halted
//   trash_count  out items currently in the bin
module robo_command_sequencer #(
  parameter int unsigned ADVANCE_CYCLES = 4,
  parameter int unsigned TURN_CYCLES    = 8,
  parameter int unsigned COLLECT_CYCLES = 6,
  parameter int unsigned BIN_CAPACITY   = 15,
  parameter int unsigned BIN_W          = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic             turn,
  input  logic             collect,
  input  logic             bin_empty,
  output logic             motor_fwd,
  output logic             motor_rot,
  output logic             arm_on,
  output logic             busy,
  output logic             ack,
  output logic             bin_full,
  output logic [BIN_W-1:0] trash_count
);

  localparam int unsigned MAX_AT  = (ADVANCE_CYCLES > TURN_CYCLES) ? ADVANCE_CYCLES : TURN_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AT > COLLECT_CYCLES) ? MAX_AT : COLLECT_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

`ifdef ROBO_BIN_LIMIT_EN
  typedef enum logic [2:0] {IDLE, ADVANCE, TURN, COLLECT, DONE, FULL} state_t;
`else
  typedef enum logic [2:0] {IDLE, ADVANCE, TURN, COLLECT, DONE} state_t;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [BIN_W-1:0] count_nxt;
  logic             at_cap;

  // Next-state, down-counter and item-count logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    count_nxt = trash_count;
    at_cap    = (trash_count == BIN_W'(BIN_CAPACITY));
    case (state)
      IDLE: begin
        if (collect) begin
          state_nxt = COLLECT;
          cnt_nxt   = CNT_W'(COLLECT_CYCLES - 1);
        end else if (turn) begin
          state_nxt = TURN;
          cnt_nxt   = CNT_W'(TURN_CYCLES - 1);
        end else if (advance) begin
          state_nxt = ADVANCE;
          cnt_nxt   = CNT_W'(ADVANCE_CYCLES - 1);
        end
      end
      ADVANCE, TURN, COLLECT: begin
        if (cnt == '0) begin
          state_nxt = DONE;
          // Saturating increment keeps the count within capacity
          if (state == COLLECT && !at_cap) begin
            count_nxt = trash_count + BIN_W'(1);
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE: begin
`ifdef ROBO_BIN_LIMIT_EN
        // A bin_empty in this cycle zeroes the count, so FULL is skipped
        state_nxt = (at_cap && !bin_empty) ? FULL : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
`ifdef ROBO_BIN_LIMIT_EN
      FULL: begin
        if (bin_empty) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    // Clear wins over a coincident collect increment
    if (bin_empty) count_nxt = '0;
  end

  // State, counters and Moore outputs registered from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      trash_count <= '0;
      motor_fwd   <= 1'b0;
      motor_rot   <= 1'b0;
      arm_on      <= 1'b0;
      busy        <= 1'b0;
      ack         <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      trash_count <= count_nxt;
      motor_fwd   <= (state_nxt == ADVANCE);
      motor_rot   <= (state_nxt == TURN);
      arm_on      <= (state_nxt == COLLECT);
      busy        <= (state_nxt != IDLE);
      ack         <= (state_nxt == DONE);
    end
  end

`ifdef ROBO_BIN_LIMIT_EN
  always_ff @(posedge clock) begin
    if (reset) bin_full <= 1'b0;
    else       bin_full <= (state_nxt == FULL);
  end
`else
  assign bin_full = 1'b0;
`endif

endmodule

// File: tb/tb_robo_command_sequencer.sv
// Self-checking bench for robo_command_sequencer. A transaction-level model
// tracks each accepted command by its acceptance cycle and length and
// derives every expected output from cycle arithmetic.
module tb_robo_command_sequencer;

  localparam int unsigned ADV = 4;
  localparam int unsigned TRN = 8;
  localparam int unsigned COL = 6;
  localparam int unsigned CAP = 2;
  localparam int unsigned BW  = 4;
`ifdef ROBO_BIN_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          advance = 1'b0, turn = 1'b0, collect = 1'b0, bin_empty = 1'b0;
  logic          motor_fwd, motor_rot, arm_on, busy, ack, bin_full;
  logic [BW-1:0] trash_count;

  always #5 clock = ~clock;

  robo_command_sequencer #(
    .ADVANCE_CYCLES(ADV), .TURN_CYCLES(TRN), .COLLECT_CYCLES(COL),
    .BIN_CAPACITY(CAP), .BIN_W(BW)
  ) dut (
    .clock(clock), .reset(reset), .advance(advance), .turn(turn),
    .collect(collect), .bin_empty(bin_empty), .motor_fwd(motor_fwd),
    .motor_rot(motor_rot), .arm_on(arm_on), .busy(busy), .ack(ack),
    .bin_full(bin_full), .trash_count(trash_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: mode 0 = idle, 1 = command in flight, 2 = bin full
  int mode  = 0;
  int kind  = 0;  // 0 advance, 1 turn, 2 collect
  int len   = 0;
  int k     = 0;  // edge on which the command was accepted
  int count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit a, input bit t, input bit c, input bit be);
    if (rst) begin
      mode  = 0;
      count = 0;
    end else begin
      case (mode)
        0: if (a || t || c) begin
          kind = c ? 2 : (t ? 1 : 0);
          len  = (kind == 2) ? COL : ((kind == 1) ? TRN : ADV);
          k    = cyc;
          mode = 1;
        end
        1: begin
          if (cyc == k + len && kind == 2 && count < CAP) count++;
          if (cyc == k + len + 1) mode = (LIMIT && count == CAP && !be) ? 2 : 0;
        end
        default: if (be) mode = 0;
      endcase
      if (be) count = 0;
    end
  endtask

  task automatic compare_all();
    int  off;
    bit  act;
    off = cyc - k;
    act = (mode == 1) && (off >= 0) && (off < len);
    chk("motor_fwd",   32'(motor_fwd),   32'(act && kind == 0));
    chk("motor_rot",   32'(motor_rot),   32'(act && kind == 1));
    chk("arm_on",      32'(arm_on),      32'(act && kind == 2));
    chk("ack",         32'(ack),         32'((mode == 1) && (off == len)));
    chk("busy",        32'(busy),        32'(mode != 0));
    chk("bin_full",    32'(bin_full),    32'(mode == 2));
    chk("trash_count", 32'(trash_count), 32'(count));
  endtask

  // One clock: drive on the falling edge, model on the rising edge, check 1 unit later
  task automatic step(input bit rst, input bit a, input bit t, input bit c, input bit be);
    @(negedge clock);
    reset = rst; advance = a; turn = t; collect = c; bin_empty = be;
    @(posedge clock);
    cyc++;
    model_edge(rst, a, t, c, be);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset, then a single advance
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(7);
    // All three requests at once: collect wins
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(8);
    // Turn, with an advance pulsed mid-turn that must be dropped
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(7);
    // Second collect reaches capacity; a further collect is ignored or saturates
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    // Empty the bin, then an advance must be accepted
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    // Reset during the third arm_on cycle
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Clear colliding with the collect increment
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(COL - 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 24) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/robo_command_sequencer.md
# robo_command_sequencer

Sequences the collector robot's one-cycle command decisions (`advance`, `turn`, `collect`) onto the shared actuator driver. Each command becomes a timed actuator pulse. The block tells the robot FSM when the actuators are busy or finished, counts collected items, and halts collection when the trash bin is full. It sits between the robot decision FSM and the motor/arm drivers.

## Interface
Parameters:
- `ADVANCE_CYCLES`, default 4: number of cycles `motor_fwd` is held per advance command (≥1).
- `TURN_CYCLES`, default 8: number of cycles `motor_rot` is held per turn command (≥1).
- `COLLECT_CYCLES`, default 6: number of cycles `arm_on` is held per collect command (≥1).
- `BIN_CAPACITY`, default 15: number of items the bin holds (1..2^`BIN_W`−1).
- `BIN_W`, default 4: width of the item counter.

Ports (name, direction, width, meaning). Clock and reset: one clock; reset is synchronous and active-high.
- `clock` in 1: single system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `advance` in 1: advance request from the robot FSM.
- `turn` in 1: turn request from the robot FSM.
- `collect` in 1: collect request from the robot FSM.
- `bin_empty` in 1: one-cycle pulse meaning the bin has been emptied.
- `motor_fwd` out 1: forward drive.
- `motor_rot` out 1: rotate drive.
- `arm_on` out 1: collector arm.
- `busy` out 1: high whenever the state is not IDLE.
- `ack` out 1: one-cycle pulse when a command completes.
- `bin_full` out 1: bin at capacity; collection halted.
- `trash_count` out `BIN_W`: number of items currently in the bin.

## Operation
States: IDLE, ADVANCE, TURN, COLLECT, DONE, FULL.
- All outputs are Moore outputs decoded from the registered state, plus `trash_count`.
- **Reset** (takes effect at any time, including mid-command): next state IDLE, down-counter 0, `trash_count`=0. All outputs are 0.
- **IDLE:** requests are sampled here and only here.
  - Priority when more than one request is high: `collect` > `turn` > `advance`.
  - The selected command loads the down-counter with its `*_CYCLES`−1 and moves to the matching state.
  - With no request, the FSM stays in IDLE.
  - Requests raised in any other state are dropped, not queued.
- **ADVANCE / TURN / COLLECT:**
  - Drive the matching actuator output high.
  - Decrement the counter each cycle.
  - When the counter equals 0, move to DONE.
  - Only one actuator output is ever high at a time.
- **DONE:**
  - `ack`=1 for exactly this one cycle.
  - If the completed command was a collect, `trash_count` increments on the edge leaving COLLECT.
  - If the new count equals `BIN_CAPACITY`, next state is FULL; otherwise IDLE.
- **FULL:**
  - `bin_full`=1, `busy`=1, and all actuators are 0.
  - All requests are ignored.
  - A `bin_empty` pulse clears `trash_count` to 0; next state is IDLE.
- **`bin_empty` in states other than FULL:** clears `trash_count` to 0 in any state. If it coincides with a collect increment, the clear wins (result 0).
- **Counter width:** the down-counter is sized to the largest `*_CYCLES`. `trash_count` never exceeds `BIN_CAPACITY`.

## Timing
- A request sampled at edge k gives:
  - actuator high in cycles k+1 … k+N, where N = the command's `*_CYCLES`;
  - `ack` high in cycle k+N+1;
  - IDLE again from cycle k+N+2.
- The earliest next acceptance is edge k+N+2, so throughput is one command per N+2 cycles.
- `busy` rises in cycle k+1 and falls at the start of cycle k+N+2.
- FULL is entered in the cycle after DONE. It is left one cycle after the `bin_empty` edge, and IDLE is reached by cycle k+2 after the pulse at edge k.

## Configuration
- `ROBO_BIN_LIMIT_EN` defined:
  - FULL state and `bin_full` behave as described above.
- `ROBO_BIN_LIMIT_EN` not defined:
  - FULL state is absent and `bin_full` is tied to 0.
  - `trash_count` saturates at `BIN_CAPACITY`.
  - DONE always returns to IDLE.
  - `bin_empty` still clears the count.

## Test plan
- **Reset then single advance:** `reset` high, then `advance` pulse at edge 2 with defaults → `motor_fwd` high in cycles 3–6, `ack` in cycle 7, `busy` low from cycle 8; all other outputs 0.
- **Simultaneous requests:** `advance`=`turn`=`collect`=1 in IDLE → only `arm_on` is high, for 6 cycles; `trash_count` goes 0→1 after the ack.
- **Drop while busy:** `turn` accepted, then `advance` pulsed mid-turn → `motor_rot` lasts exactly 8 cycles, `motor_fwd` never rises, single `ack`.
- **Bin full (macro on, `BIN_CAPACITY`=2):**
  - Two collects → `bin_full`=1 and `trash_count`=2.
  - A further collect is ignored.
  - A `bin_empty` pulse → `trash_count`=0 and the FSM returns to IDLE; the next advance is accepted.
- **Reset mid-collect:** `reset` in the 3rd `arm_on` cycle → all outputs 0 the next cycle, `trash_count`=0, no `ack`.
- **Clear vs increment collision:** `bin_empty` asserted on the COLLECT→DONE edge → `trash_count`=0.
